// File: rtl/game_pkg.sv
// Shared types and constants for the LED counting game round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW   = 3'd1,
    JUDGE  = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Score trigger lines idle high and pulse low for one cycle
  localparam logic TRIG_IDLE = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam int DEF_NUM_Q     = 11;
  localparam int DEF_WIN_SCORE = 5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_round_ctrl_btn_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse for one button.
// A level rising at edge N gives a pulse that the consumer sees at edge N+3.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [1:0] sync;
  logic       prev;

  // Synchronize, remember the last level, and register the 0->1 transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= 2'b00;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      prev <= sync[1];
      rise <= sync[1] & ~prev;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the LED counting game: steps the question index,
// arbitrates buzzers, judges answers and emits active-low score pulses.
// Optional macro GAME_ROUND_PENALTY_EN: a wrong answer locks that player out
// for the rest of the question instead of ending it.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int NUM_Q       = DEF_NUM_Q,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int RESULT_CYC  = 25_000_000,
  parameter int WIN_SCORE   = DEF_WIN_SCORE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       buzz_p1,
  input  logic       buzz_p2,
  input  logic [3:0] ans_p1,
  input  logic [3:0] ans_p2,
  input  logic [3:0] bcd_ans,
  output logic [3:0] bcd_state,
  output logic       score_trig_p1,
  output logic       score_trig_p2,
  output logic       question_active,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int TW_RAW = $clog2(max2(TIMEOUT_CYC, RESULT_CYC));
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int SW     = $clog2(WIN_SCORE + 1);

  localparam logic [TW-1:0] T_SHOW = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_RES  = TW'(RESULT_CYC - 1);
  localparam logic [3:0]    LAST_Q = 4'(NUM_Q - 1);
  localparam logic [SW-1:0] WIN    = SW'(WIN_SCORE);

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    bcd_n;
  logic [SW-1:0] score1, score1_n, score2, score2_n;
  logic          who, who_n;      // 0: p1 buzzed, 1: p2 buzzed
  logic [3:0]    ans_q, ans_n;
  logic          tie, tie_n;      // 0: p1 wins next simultaneous buzz
  logic          lock1, lock1_n, lock2, lock2_n;
  logic          trig1, trig2;
  logic          ev_start, ev_b1, ev_b2, b1, b2;

  btn_edge_sync u_sync_start (.clk(clk), .rst_n(rst_n), .btn(start),   .rise(ev_start));
  btn_edge_sync u_sync_p1    (.clk(clk), .rst_n(rst_n), .btn(buzz_p1), .rise(ev_b1));
  btn_edge_sync u_sync_p2    (.clk(clk), .rst_n(rst_n), .btn(buzz_p2), .rise(ev_b2));

  // Locked-out players' buzzes never reach the arbiter
  assign b1 = ev_b1 & ~lock1;
  assign b2 = ev_b2 & ~lock2;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bcd_state <= 4'd0;
      score1    <= '0;
      score2    <= '0;
      who       <= 1'b0;
      ans_q     <= 4'd0;
      tie       <= 1'b0;
      lock1     <= 1'b0;
      lock2     <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bcd_state <= bcd_n;
      score1    <= score1_n;
      score2    <= score2_n;
      who       <= who_n;
      ans_q     <= ans_n;
      tie       <= tie_n;
      lock1     <= lock1_n;
      lock2     <= lock2_n;
    end
  end

  // Next-state, datapath updates and score pulse generation
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    bcd_n    = bcd_state;
    score1_n = score1;
    score2_n = score2;
    who_n    = who;
    ans_n    = ans_q;
    tie_n    = tie;
    lock1_n  = lock1;
    lock2_n  = lock2;
    trig1    = TRIG_IDLE;
    trig2    = TRIG_IDLE;
    case (state)
      IDLE: begin
        bcd_n = 4'd0;
        if (ev_start) begin
          state_n = SHOW;
          timer_n = T_SHOW;
        end
      end
      SHOW: begin
        // A buzz beats a simultaneous timeout; timer freezes while judging
        if (b1 | b2) begin
          state_n = JUDGE;
          if (b1 & b2) begin
            who_n = tie;
            tie_n = ~tie;
          end else begin
            who_n = b2;
          end
          ans_n = who_n ? ans_p2 : ans_p1;
        end else if (timer == '0) begin
          state_n = RESULT;
          timer_n = T_RES;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      JUDGE: begin
        state_n = RESULT;
        timer_n = T_RES;
        if (ans_q == bcd_ans) begin
          if (who) begin
            trig2 = ~TRIG_IDLE;
            if (score2 != WIN) score2_n = score2 + 1'b1;
          end else begin
            trig1 = ~TRIG_IDLE;
            if (score1 != WIN) score1_n = score1 + 1'b1;
          end
        end
`ifdef GAME_ROUND_PENALTY_EN
        else begin
          // Wrong answer: lock the player out and resume the same question
          if (who) lock2_n = 1'b1;
          else     lock1_n = 1'b1;
          if (!(lock1_n & lock2_n)) begin
            state_n = SHOW;
            timer_n = timer;
          end
        end
`endif
      end
      RESULT: begin
        if (timer == '0) begin
          if (score1 == WIN || score2 == WIN || bcd_state == LAST_Q) begin
            state_n = DONE;
          end else begin
            state_n = SHOW;
            timer_n = T_SHOW;
            bcd_n   = bcd_state + 4'd1;
            lock1_n = 1'b0;
            lock2_n = 1'b0;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // A reset arriving during JUDGE suppresses the pulse immediately
  assign score_trig_p1   = trig1 | ~rst_n;
  assign score_trig_p2   = trig2 | ~rst_n;
  assign question_active = (state == SHOW);
  assign game_over       = (state == DONE);

  // Winner is only meaningful once the game has ended
  always_comb begin
    winner = WIN_NONE;
    if (state == DONE) begin
      if (score1 > score2)      winner = WIN_P1;
      else if (score2 > score1) winner = WIN_P2;
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with short timers (SHOW 8, RESULT 4).
module tb_game_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, buzz_p1 = 1'b0, buzz_p2 = 1'b0;
  logic [3:0] ans_p1 = 4'd0, ans_p2 = 4'd0, bcd_ans = 4'd0;
  logic [3:0] bcd_state;
  logic       score_trig_p1, score_trig_p2, question_active, game_over;
  logic [1:0] winner;

  int total = 0;
  int passed = 0;
  int lo1 = 0;
  int lo2 = 0;

  game_round_ctrl #(
    .NUM_Q(11), .TIMEOUT_CYC(8), .RESULT_CYC(4), .WIN_SCORE(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .buzz_p1(buzz_p1), .buzz_p2(buzz_p2),
    .ans_p1(ans_p1), .ans_p2(ans_p2), .bcd_ans(bcd_ans),
    .bcd_state(bcd_state),
    .score_trig_p1(score_trig_p1), .score_trig_p2(score_trig_p2),
    .question_active(question_active), .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  // Count low trigger cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (score_trig_p1 === 1'b0) lo1++;
    if (score_trig_p2 === 1'b0) lo2++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; buzz_p1 = 1'b0; buzz_p2 = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Leaves the bench in the first SHOW cycle of question 0
  task automatic start_game();
    start = 1'b1; tick(1); start = 1'b0; tick(3);
  endtask

  // Leaves the bench in the JUDGE cycle
  task automatic buzz(input logic b1, input logic b2);
    buzz_p1 = b1; buzz_p2 = b2; tick(1);
    buzz_p1 = 1'b0; buzz_p2 = 1'b0; tick(3);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bcd_state !== 4'd0) $display("FAIL reset_bcd got %0d want 0", bcd_state); else passed++;
    total++; if (score_trig_p1 !== 1'b1) $display("FAIL reset_trig1 got %b want 1", score_trig_p1); else passed++;
    total++; if (score_trig_p2 !== 1'b1) $display("FAIL reset_trig2 got %b want 1", score_trig_p2); else passed++;
    total++; if (question_active !== 1'b0) $display("FAIL reset_qa got %b want 0", question_active); else passed++;
    total++; if (game_over !== 1'b0) $display("FAIL reset_go got %b want 0", game_over); else passed++;
    total++; if (winner !== 2'd0) $display("FAIL reset_winner got %0d want 0", winner); else passed++;
  endtask

  task automatic test_start();
    do_reset();
    start = 1'b1; tick(1); start = 1'b0; tick(2);
    total++; if (question_active !== 1'b0) $display("FAIL start_early got %b want 0", question_active); else passed++;
    tick(1);
    total++; if (question_active !== 1'b1) $display("FAIL start_show got %b want 1", question_active); else passed++;
    total++; if (bcd_state !== 4'd0) $display("FAIL start_bcd got %0d want 0", bcd_state); else passed++;
    total++; if ({score_trig_p1, score_trig_p2} !== 2'b11) $display("FAIL start_trig got %b want 11", {score_trig_p1, score_trig_p2}); else passed++;
  endtask

  task automatic test_correct_p1();
    int b1, b2;
    do_reset();
    bcd_ans = 4'd1; ans_p1 = 4'd1; ans_p2 = 4'd9;
    start_game();
    b1 = lo1; b2 = lo2;
    buzz(1'b1, 1'b0);
    total++; if (score_trig_p1 !== 1'b0) $display("FAIL p1_pulse got %b want 0", score_trig_p1); else passed++;
    total++; if (score_trig_p2 !== 1'b1) $display("FAIL p1_other got %b want 1", score_trig_p2); else passed++;
    tick(4);
    total++; if (bcd_state !== 4'd0) $display("FAIL p1_bcd_hold got %0d want 0", bcd_state); else passed++;
    total++; if (question_active !== 1'b0) $display("FAIL p1_result_qa got %b want 0", question_active); else passed++;
    tick(1);
    total++; if (bcd_state !== 4'd1) $display("FAIL p1_bcd_next got %0d want 1", bcd_state); else passed++;
    total++; if (lo1 - b1 !== 1) $display("FAIL p1_pulse_len got %0d want 1", lo1 - b1); else passed++;
    total++; if (lo2 - b2 !== 0) $display("FAIL p1_p2_quiet got %0d want 0", lo2 - b2); else passed++;
  endtask

  task automatic test_tie();
    int b1, b2;
    do_reset();
    bcd_ans = 4'd3; ans_p1 = 4'd3; ans_p2 = 4'd5;
    start_game();
    b1 = lo1; b2 = lo2;
    buzz(1'b1, 1'b1);
    total++; if (score_trig_p1 !== 1'b0) $display("FAIL tie1_p1 got %b want 0", score_trig_p1); else passed++;
    tick(5);
    total++; if (bcd_state !== 4'd1) $display("FAIL tie_bcd got %0d want 1", bcd_state); else passed++;
    buzz(1'b1, 1'b1);
    total++; if ({score_trig_p1, score_trig_p2} !== 2'b11) $display("FAIL tie2_trig got %b want 11", {score_trig_p1, score_trig_p2}); else passed++;
    tick(2);
    total++; if (lo1 - b1 !== 1) $display("FAIL tie_p1_count got %0d want 1", lo1 - b1); else passed++;
    total++; if (lo2 - b2 !== 0) $display("FAIL tie_p2_count got %0d want 0", lo2 - b2); else passed++;
  endtask

  task automatic test_timeout();
    int b1, b2;
    do_reset();
    start_game();
    b1 = lo1; b2 = lo2;
    tick(8);
    total++; if (question_active !== 1'b0) $display("FAIL to_result_qa got %b want 0", question_active); else passed++;
    total++; if (bcd_state !== 4'd0) $display("FAIL to_result_bcd got %0d want 0", bcd_state); else passed++;
    tick(4);
    total++; if (bcd_state !== 4'd1) $display("FAIL to_bcd1 got %0d want 1", bcd_state); else passed++;
    for (int q = 2; q <= 10; q++) begin
      tick(12);
      total++; if (bcd_state !== 4'(q)) $display("FAIL to_bcd got %0d want %0d", bcd_state, q); else passed++;
    end
    tick(12);
    total++; if (game_over !== 1'b1) $display("FAIL to_done got %b want 1", game_over); else passed++;
    total++; if (winner !== 2'd0) $display("FAIL to_winner got %0d want 0", winner); else passed++;
    total++; if (bcd_state !== 4'd10) $display("FAIL to_last got %0d want 10", bcd_state); else passed++;
    start = 1'b1; tick(6); start = 1'b0;
    total++; if (game_over !== 1'b1 || question_active !== 1'b0) $display("FAIL to_done_sticky got go=%b qa=%b want go=1 qa=0", game_over, question_active); else passed++;
    total++; if (lo1 - b1 + lo2 - b2 !== 0) $display("FAIL to_no_pulse got %0d want 0", lo1 - b1 + lo2 - b2); else passed++;
  endtask

  task automatic test_win();
    do_reset();
    bcd_ans = 4'd7; ans_p1 = 4'd7;
    start_game();
    for (int i = 0; i < 5; i++) begin
      buzz(1'b1, 1'b0);
      total++; if (score_trig_p1 !== 1'b0) $display("FAIL win_pulse%0d got %b want 0", i, score_trig_p1); else passed++;
      tick(5);
      if (i < 4) begin
        total++; if (bcd_state !== 4'(i + 1)) $display("FAIL win_bcd got %0d want %0d", bcd_state, i + 1); else passed++;
      end
    end
    total++; if (game_over !== 1'b1) $display("FAIL win_done got %b want 1", game_over); else passed++;
    total++; if (winner !== 2'd1) $display("FAIL win_winner got %0d want 1", winner); else passed++;
    total++; if (bcd_state !== 4'd4) $display("FAIL win_bcd_final got %0d want 4", bcd_state); else passed++;
  endtask

  task automatic test_reset_judge();
    int b1;
    do_reset();
    bcd_ans = 4'd2; ans_p1 = 4'd2;
    start_game();
    buzz(1'b1, 1'b0);
    b1 = lo1;
    rst_n = 1'b0;
    #1;
    total++; if (score_trig_p1 !== 1'b1) $display("FAIL rj_trig got %b want 1", score_trig_p1); else passed++;
    @(posedge clk); #1;
    total++; if (bcd_state !== 4'd0 || question_active !== 1'b0 || game_over !== 1'b0) $display("FAIL rj_idle got bcd=%0d qa=%b go=%b want 0/0/0", bcd_state, question_active, game_over); else passed++;
    rst_n = 1'b1;
    tick(6);
    total++; if (question_active !== 1'b0) $display("FAIL rj_stay_idle got %b want 0", question_active); else passed++;
    total++; if (lo1 - b1 !== 0) $display("FAIL rj_no_pulse got %0d want 0", lo1 - b1); else passed++;
  endtask

`ifdef GAME_ROUND_PENALTY_EN
  task automatic test_penalty();
    int b1, b2;
    do_reset();
    bcd_ans = 4'd4; ans_p1 = 4'd1; ans_p2 = 4'd4;
    start_game();
    b1 = lo1; b2 = lo2;
    buzz(1'b1, 1'b0);
    tick(1);
    total++; if (question_active !== 1'b1) $display("FAIL pen_back_show got %b want 1", question_active); else passed++;
    buzz(1'b1, 1'b1);
    total++; if (score_trig_p2 !== 1'b0) $display("FAIL pen_p2_pulse got %b want 0", score_trig_p2); else passed++;
    tick(1);
    total++; if (lo1 - b1 !== 0) $display("FAIL pen_p1_quiet got %0d want 0", lo1 - b1); else passed++;
    total++; if (lo2 - b2 !== 1) $display("FAIL pen_p2_count got %0d want 1", lo2 - b2); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_correct_p1();
    test_tie();
    test_timeout();
    test_win();
    test_reset_judge();
`ifdef GAME_ROUND_PENALTY_EN
    test_penalty();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
